// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, queue entry and constants.
// No logic; latency and backpressure are defined by the modules that import it.
package instr_fetch_sequencer_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/instr_fetch_sequencer_fetch_queue.sv
// Fetch queue: power-of-two FIFO of {pc, instr}; head visible combinationally, push-to-head 1 cycle.
// Push while full is accepted only together with a pop; flush empties it and overrides push/pop.
module fetch_queue
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fq_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output fq_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is pure datapath; the head is masked by empty at the top level.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, responses queued for decode (grant-to-visible 2 cycles).
// Stops requesting when queue plus in-flight would overflow; decode stall holds the head stable.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [31:0]     if_pc,
    output logic            busy
);

    fetch_state_t               state;
    logic [31:0]                fetch_pc;
    logic [31:0]                inflight_pc;
    logic [31:0]                redirect_target;
    logic                       accept;
    logic                       redirect;
    logic                       push;
    logic                       pop;
    logic                       fq_full;
    logic                       fq_empty;
    logic [$clog2(FQ_DEPTH):0]  fq_count;
    fq_entry_t                  fq_head;
    fq_entry_t                  push_entry;

    // The very first post-reset cycle samples no input, so IDLE ignores redirects.
    assign redirect        = redirect_valid && (state != IDLE);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Only REQ can issue, and nothing is outstanding there, so room == not full.
    assign imem_req  = (state == REQ) && !fq_full;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_gnt;

    assign push       = (state == WAIT) && imem_rvalid && !redirect;
    assign pop        = !fq_empty && if_ready && !redirect;
    assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

    assign if_valid = !fq_empty;
    assign if_instr = fq_empty ? NOP_INSTR : fq_head.instr;
    assign if_pc    = fq_empty ? RESET_PC  : fq_head.pc;
    assign busy     = (state == WAIT) || (state == DRAIN) || (fq_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (accept) begin
                        inflight_pc <= fetch_pc;
                        fetch_pc    <= fetch_pc + 32'd4;
                        state       <= redirect ? DRAIN : WAIT;
                    end
                    if (redirect) fetch_pc <= redirect_target;
                end
                WAIT: begin
                    // A response landing in the redirect cycle is already the one to drop.
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                        state    <= imem_rvalid ? REQ : DRAIN;
                    end else if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirect)    fetch_pc <= redirect_target;
                    if (imem_rvalid) state    <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (fq_head),
        .full       (fq_full),
        .empty      (fq_empty),
        .count      (fq_count)
    );

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus a randomized run against a queue-level model.
module tb_instr_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int gnt_pct  = 100;
    int lat_min  = 1;
    int lat_max  = 1;
    int spur_pct = 0;

    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;

    always #5 clk = ~clk;

    instr_fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .busy           (busy)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0000_0093;
            32'h8:   return 32'h0010_0113;
            default: return a ^ 32'h5EED_0000;
        endcase
    endfunction

    // Memory side: records a handshake at the end of the cycle, answers after lat_min..lat_max cycles.
    task automatic tick();
        #1;
        if (rst_n && imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_wait = $urandom_range(lat_max, lat_min) - 1;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (pend_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_wait--;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            imem_rvalid = 1'b1;
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        pend           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_gnt = ($urandom_range(99) < gnt_pct);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0;
        #3;
        total++; if (imem_req !== 1'b0)     begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
        total++; if (if_valid !== 1'b0)     begin bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        total++; if (if_instr !== NOP)      begin bad++; $display("FAIL rst_instr: got %h want %h", if_instr, NOP); end
        total++; if (if_pc !== RESET_PC)    begin bad++; $display("FAIL rst_pc: got %h want %h", if_pc, RESET_PC); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        do_reset();
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
        tick();
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_basic();
        int first_gnt, first_vld, n;
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        int at [3];
        first_gnt = -1; first_vld = -1; n = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0; if_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 30 && n < 3; k++) begin
            #1;
            if (imem_req && imem_gnt && first_gnt < 0) first_gnt = k;
            if (if_valid && first_vld < 0) first_vld = k;
            if (if_valid && if_ready) begin pcs[n] = if_pc; ins[n] = if_instr; at[n] = k; n++; end
            tick();
        end
        total++; if (n != 3) begin bad++; $display("FAIL basic_count: got %0d want 3", n); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (pcs[i] !== 32'(4 * i) || ins[i] !== word(32'(4 * i))) begin
                bad++; $display("FAIL basic_seq%0d: got pc=%h instr=%h want pc=%h instr=%h",
                                i, pcs[i], ins[i], 32'(4 * i), word(32'(4 * i)));
            end
        end
        total++;
        if (first_gnt < 0 || first_vld - first_gnt != 2) begin
            bad++; $display("FAIL first_latency: got %0d want 2", first_vld - first_gnt);
        end
        if (n == 3) begin
            total++; if (at[2] - at[1] != 2) begin bad++; $display("FAIL throughput: got %0d want 2", at[2] - at[1]); end
        end
    endtask

    task automatic test_stall();
        int acc;
        acc = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0; if_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            if (imem_req && imem_gnt) acc++;
            tick();
        end
        #1;
        total++; if (acc != FQ_DEPTH) begin bad++; $display("FAIL stall_fill: got %0d want %0d", acc, FQ_DEPTH); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", imem_req); end
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin
            bad++; $display("FAIL stall_head: got v=%b pc=%h instr=%h want v=1 pc=0 instr=13", if_valid, if_pc, if_instr);
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b want 1", busy); end
        if_ready = 1'b1;
        tick();
        #1;
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h93) begin
            bad++; $display("FAIL stall_second: got v=%b pc=%h instr=%h want v=1 pc=4 instr=93", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect();
        bit found, got;
        logic [31:0] fpc, fin;
        found = 0; got = 0; fpc = '0; fin = '0;
        gnt_pct = 100; lat_min = 3; lat_max = 3; spur_pct = 0; if_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 40 && !found; k++) begin
            #1;
            if (imem_req && imem_gnt && imem_addr == 32'h8) found = 1;
            tick();
        end
        total++; if (!found) begin bad++; $display("FAIL redir_setup: got no grant at 8 want one"); end
        pulse_redirect(32'h100);
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", if_valid); end
        for (int k = 0; k < 40 && !got; k++) begin
            if (if_valid && if_ready) begin got = 1; fpc = if_pc; fin = if_instr; end
            tick();
            #1;
        end
        total++;
        if (!got || fpc !== 32'h100 || fin !== word(32'h100)) begin
            bad++; $display("FAIL redir_target: got seen=%b pc=%h instr=%h want pc=100 instr=%h", got, fpc, fin, word(32'h100));
        end
    endtask

    task automatic test_drain_redirect();
        bit found, seen_acc, got;
        logic [31:0] acc_addr, fpc, fin;
        found = 0; seen_acc = 0; got = 0; acc_addr = '0; fpc = '0; fin = '0;
        gnt_pct = 100; lat_min = 3; lat_max = 3; spur_pct = 0; if_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (imem_req && imem_gnt) found = 1;
            tick();
        end
        pulse_redirect(32'h40);
        pulse_redirect(32'h300);
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (imem_req && imem_gnt && !seen_acc) begin seen_acc = 1; acc_addr = imem_addr; end
            if (if_valid && if_ready) begin got = 1; fpc = if_pc; fin = if_instr; end
            tick();
        end
        total++;
        if (!seen_acc || acc_addr !== 32'h300) begin
            bad++; $display("FAIL drain_req: got seen=%b addr=%h want addr=300", seen_acc, acc_addr);
        end
        total++;
        if (!got || fpc !== 32'h300 || fin !== word(32'h300)) begin
            bad++; $display("FAIL drain_pop: got seen=%b pc=%h instr=%h want pc=300 instr=%h", got, fpc, fin, word(32'h300));
        end
    endtask

    task automatic test_align();
        bit seen_req, got;
        logic [31:0] req_addr, fpc;
        seen_req = 0; got = 0; req_addr = '0; fpc = '0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0; if_ready = 1'b1;
        do_reset();
        repeat (5) tick();
        pulse_redirect(32'h203);
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (imem_req && !seen_req) begin seen_req = 1; req_addr = imem_addr; end
            if (if_valid && if_ready) begin got = 1; fpc = if_pc; end
            tick();
        end
        total++; if (req_addr !== 32'h200) begin bad++; $display("FAIL align_addr: got %h want 00000200", req_addr); end
        total++; if (!got || fpc !== 32'h200) begin bad++; $display("FAIL align_pc: got %h want 00000200", fpc); end
    endtask

    task automatic test_wrap();
        int na, np;
        logic [31:0] accs [2];
        logic [31:0] pops [2];
        na = 0; np = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0; if_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        pulse_redirect(32'hFFFF_FFFC);
        for (int k = 0; k < 30 && np < 2; k++) begin
            #1;
            if (imem_req && imem_gnt && na < 2) begin accs[na] = imem_addr; na++; end
            if (if_valid && if_ready) begin pops[np] = if_pc; np++; end
            tick();
        end
        total++;
        if (na != 2 || accs[0] !== 32'hFFFF_FFFC || accs[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h want a0=fffffffc a1=00000000", na, accs[0], accs[1]);
        end
        total++;
        if (np != 2 || pops[0] !== 32'hFFFF_FFFC || pops[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_pc: got n=%0d p0=%h p1=%h want p0=fffffffc p1=00000000", np, pops[0], pops[1]);
        end
    endtask

    task automatic test_reset_midwait();
        bit found, seen_acc, got;
        logic [31:0] acc_addr, fpc, fin;
        found = 0; seen_acc = 0; got = 0; acc_addr = '1; fpc = '1; fin = '0;
        gnt_pct = 100; lat_min = 3; lat_max = 3; spur_pct = 0; if_ready = 1'b1;
        do_reset();
        repeat (6) tick();
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (imem_req && imem_gnt) found = 1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, if_valid, if_instr, if_pc, busy} !== {1'b0, RESET_PC, 1'b0, NOP, RESET_PC, 1'b0}) begin
            bad++; $display("FAIL midwait_rst: got req=%b addr=%h v=%b instr=%h pc=%h busy=%b want 0/%h/0/%h/%h/0",
                            imem_req, imem_addr, if_valid, if_instr, if_pc, busy, RESET_PC, NOP, RESET_PC);
        end
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (imem_req && imem_gnt && !seen_acc) begin seen_acc = 1; acc_addr = imem_addr; end
            if (if_valid && if_ready) begin got = 1; fpc = if_pc; fin = if_instr; end
            tick();
        end
        total++; if (acc_addr !== RESET_PC) begin bad++; $display("FAIL restart_addr: got %h want %h", acc_addr, RESET_PC); end
        total++;
        if (!got || fpc !== RESET_PC || fin !== word(RESET_PC)) begin
            bad++; $display("FAIL restart_pop: got pc=%h instr=%h want pc=%h instr=%h", fpc, fin, RESET_PC, word(RESET_PC));
        end
    endtask

    // Model: the queue holds exactly the responses of live requests, in order; a redirect kills all of them.
    task automatic test_random();
        ent_t        q[$];
        bit          started, outst, live, exp_valid, exp_req, exp_busy;
        logic [31:0] exp_pc, out_addr;
        started = 0; outst = 0; live = 0; exp_pc = RESET_PC; out_addr = '0;
        gnt_pct = 70; lat_min = 1; lat_max = 3; spur_pct = 5;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if_ready       = ($urandom_range(99) < 60);
            redirect_valid = started && ($urandom_range(99) < 4);
            redirect_pc    = $urandom;
            #1;
            exp_valid = (q.size() != 0);
            exp_req   = started && !outst && (q.size() < FQ_DEPTH);
            exp_busy  = outst || (q.size() != 0);
            total++; if (if_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid @%0d: got %b want %b", i, if_valid, exp_valid); end
            if (exp_valid) begin
                total++;
                if (if_pc !== q[0].pc || if_instr !== q[0].instr) begin
                    bad++; $display("FAIL rnd_head @%0d: got %h/%h want %h/%h", i, if_pc, if_instr, q[0].pc, q[0].instr);
                end
            end
            total++; if (imem_req !== exp_req) begin bad++; $display("FAIL rnd_req @%0d: got %b want %b", i, imem_req, exp_req); end
            if (exp_req) begin
                total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL rnd_addr @%0d: got %h want %h", i, imem_addr, exp_pc); end
            end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, exp_busy); end
            if (exp_valid && if_ready && !redirect_valid) void'(q.pop_front());
            if (outst && imem_rvalid) begin
                if (live && !redirect_valid) q.push_back('{pc: out_addr, instr: word(out_addr)});
                outst = 0;
            end
            if (exp_req && imem_gnt) begin
                outst    = 1;
                live     = !redirect_valid;
                out_addr = exp_pc;
                exp_pc   = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                q.delete();
                exp_pc = {redirect_pc[31:2], 2'b00};
                live   = 0;
            end
            started = 1;
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_drain_redirect();
        test_align();
        test_wrap();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
